// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain end of an 8-bit synchronous FIFO. Pops one byte at a time through the
// FIFO read handshake and serialises it on a UART line as 8N1, LSB first.
//
// Frame timing, with C = CLKS_PER_BIT:
//   IDLE -> REQ -> WAIT    fetch: three cycles of idle-high line
//   START                  C cycles of tx=0
//   DATA                   8 bits, C cycles each, LSB first
//   STOP                   C cycles of tx=1; tx_done pulses on the last one
// Back-to-back frames therefore have 3 idle-high cycles between the end of one
// stop bit and the start bit of the next frame.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   DATA_W        bits per frame; must match the FIFO width (only 8 supported)
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   enable      permits fetching a new byte; only looked at in IDLE
//   fifo_empty  FIFO empty flag; only looked at in IDLE
//   fifo_data   FIFO data_out; valid the cycle after an accepted fifo_rd_en
//   fifo_rd_en  one-cycle pop request to the FIFO (registered, high in REQ)
//   tx          serial line, idle high (registered)
//   busy        high from REQ through the end of STOP
//   tx_done     one-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CNT_W-1:0]  clk_cnt;   // cycle within the current bit period
  logic [BIT_W-1:0]  bit_cnt;   // data bit currently on the line
  logic [DATA_W-1:0] shift;     // byte in flight; bit 0 is on the line in DATA

  logic              bit_end;   // last cycle of the current bit period
  logic              fetch;     // a byte may be popped this cycle

  assign bit_end = (clk_cnt == CNT_LAST);
  assign fetch   = enable && !fifo_empty;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so that no path leaves it
  // unassigned; an unassigned path in a combinational block infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (fetch) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && (bit_cnt == BIT_LAST)) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (state-decoded flags)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = 1'b0;
    tx_done = 1'b0;
    unique case (state)
      S_IDLE:  busy = 1'b0;
      S_REQ,
      S_WAIT,
      S_START,
      S_DATA:  busy = 1'b1;
      S_STOP: begin
        busy    = 1'b1;
        tx_done = bit_end;
      end
      default: busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: line driver, pop request, shift register and counters
  //
  // tx is registered, so each branch assigns the value the line takes in the
  // *next* state. That is why the start bit is launched in WAIT and the first
  // data bit is launched on the last cycle of START.
  // ---------------------------------------------------------------------------
  // NOTE: the shift register and counters are reset along with the control
  // state so a frame aborted by reset leaves no stale byte behind; they are a
  // handful of flops, not a memory array, so resetting them costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      shift      <= '0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
    end else begin
      // The pop request lives for exactly the one cycle spent in REQ.
      fifo_rd_en <= 1'b0;

      unique case (state)
        S_IDLE: begin
          tx         <= 1'b1;
          clk_cnt    <= '0;
          fifo_rd_en <= fetch;
        end

        S_REQ: begin
          // FIFO pops at the end of this cycle; its data_out is valid in WAIT.
          tx <= 1'b1;
        end

        S_WAIT: begin
          shift   <= fifo_data;
          tx      <= 1'b0;
          bit_cnt <= '0;
          clk_cnt <= '0;
        end

        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              tx <= 1'b1;
            end else begin
              // Bit 1 of the current shift value is the next bit on the line.
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            clk_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Bench for fifo_uart_tx with CLKS_PER_BIT=4. A small behavioural FIFO feeds
// the block. A line monitor captures every frame as 40 per-cycle samples of tx
// and tx_done, starting at the falling edge of the start bit, and records the
// idle-high run that preceded it. Expected frames are built from the byte value
// alone: start bit, 8 data bits LSB first, stop bit, each held 4 cycles.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;   // frame length in clk cycles

  localparam logic [FL-1:0] DONE_EXP = {1'b1, {(FL-1){1'b0}}};

  typedef struct {
    logic [FL-1:0] line;
    logic [FL-1:0] done;
    int            gap;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  // Bench-side FIFO write port.
  logic       wr_en;
  logic [7:0] wr_data;

  int total = 0;
  int bad   = 0;

  // Monitor statistics.
  int     rd_cnt   = 0;
  int     done_cnt = 0;
  int     bad_pop  = 0;
  frame_t frames[$];
  int     last_gap = 0;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural synchronous FIFO, 16 deep. Not reset by rst: the UART block's
  // reset must not disturb bytes still queued upstream.
  // ---------------------------------------------------------------------------
  logic [7:0] fmem [0:15];
  logic [3:0] wptr   = '0;
  logic [3:0] rptr   = '0;
  logic [4:0] fcount = '0;
  logic       pop;

  assign pop        = fifo_rd_en && (fcount != 5'd0);
  assign fifo_empty = (fcount == 5'd0);

  initial fifo_data = 8'h00;

  always @(posedge clk) begin
    if (wr_en) begin
      fmem[wptr] <= wr_data;
      wptr       <= wptr + 4'd1;
    end
    if (pop) begin
      fifo_data <= fmem[rptr];
      rptr      <= rptr + 4'd1;
    end
    fcount <= fcount + (wr_en ? 5'd1 : 5'd0) - (pop ? 5'd1 : 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Line monitor, sampling on the falling edge.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [FL-1:0] cap_line;
    logic [FL-1:0] cap_done;
    int            cap_idx;
    int            cap_gap;
    int            idle_run;
    bit            cap_on;
    frame_t        f;
    cap_on   = 1'b0;
    cap_idx  = 0;
    cap_gap  = 0;
    idle_run = 0;
    cap_line = '0;
    cap_done = '0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (tx_done === 1'b1) done_cnt++;
      if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) bad_pop++;
      if (rst) begin
        cap_on   = 1'b0;
        idle_run = 0;
      end else if (!cap_on) begin
        if (tx === 1'b0) begin
          cap_on      = 1'b1;
          cap_line    = '0;
          cap_done    = '0;
          cap_line[0] = tx;
          cap_done[0] = tx_done;
          cap_idx     = 1;
          cap_gap     = idle_run;
        end else begin
          idle_run++;
        end
      end else begin
        cap_line[cap_idx] = tx;
        cap_done[cap_idx] = tx_done;
        if (cap_idx == FL - 1) begin
          f.line = cap_line;
          f.done = cap_done;
          f.gap  = cap_gap;
          frames.push_back(f);
          cap_on   = 1'b0;
          idle_run = 0;
        end else begin
          cap_idx++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle tx samples for one 8N1 frame of byte b.
  function automatic logic [FL-1:0] exp_line(input logic [7:0] b);
    logic [FL-1:0] l;
    logic          v;
    l = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = 1'b1;
      else             v = b[k-1];
      for (int c = 0; c < CPB; c++) l[k*CPB + c] = v;
    end
    return l;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b);
    frame_t f;
    int     n;
    n = 0;
    while (frames.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (frames.size() == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      f = frames.pop_front();
      check({tag, "_line"}, 64'(f.line), 64'(exp_line(b)));
      check({tag, "_done"}, 64'(f.done), 64'(DONE_EXP));
      last_gap = f.gap;
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) check({tag, "_start_timeout"}, 64'd0, 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    int         viol;
    int         rd0;
    int         dn0;
    logic [7:0] rb;
    logic [7:0] rand_q[$];

    rst     = 1'b1;
    enable  = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // Reset values and idle behaviour with an empty FIFO.
    repeat (2) @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_tx_done", 64'(tx_done), 64'd0);
    rst  = 1'b0;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) viol++;
    end
    check("idle_empty_viol", 64'(viol), 64'd0);

    // Single byte.
    rd0 = rd_cnt;
    dn0 = done_cnt;
    push_byte(8'h05);
    expect_frame("single_05", 8'h05);
    repeat (6) @(negedge clk);
    check("single_rd_pulses", 64'(rd_cnt - rd0), 64'd1);
    check("single_done_pulses", 64'(done_cnt - dn0), 64'd1);
    check("single_empty_after", 64'(fifo_empty), 64'd1);
    check("single_busy_after", 64'(busy), 64'd0);

    // Back-to-back frames with the minimum fetch gap.
    rd0 = rd_cnt;
    dn0 = done_cnt;
    push_byte(8'h05);
    push_byte(8'h0A);
    expect_frame("b2b_first", 8'h05);
    expect_frame("b2b_second", 8'h0A);
    check("b2b_gap", 64'(last_gap), 64'd3);
    repeat (6) @(negedge clk);
    check("b2b_rd_pulses", 64'(rd_cnt - rd0), 64'd2);
    check("b2b_done_pulses", 64'(done_cnt - dn0), 64'd2);

    // Enable gating: byte waits in the FIFO until enable returns.
    enable = 1'b0;
    rd0    = rd_cnt;
    push_byte(8'hFF);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1) viol++;
    end
    check("gate_viol", 64'(viol), 64'd0);
    check("gate_rd_pulses", 64'(rd_cnt - rd0), 64'd0);
    check("gate_not_empty", 64'(fifo_empty), 64'd0);
    enable = 1'b1;
    expect_frame("gate_ff", 8'hFF);

    // Enable dropped during DATA: current frame finishes, next byte stays put.
    repeat (6) @(negedge clk);
    rd0 = rd_cnt;
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_start("middis");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    expect_frame("middis_a5", 8'hA5);
    repeat (20) @(negedge clk);
    check("middis_no_frame", 64'(frames.size()), 64'd0);
    check("middis_not_empty", 64'(fifo_empty), 64'd0);
    check("middis_rd_pulses", 64'(rd_cnt - rd0), 64'd1);
    enable = 1'b1;
    expect_frame("middis_3c", 8'h3C);

    // Reset during data bit 3: line goes high immediately, byte is dropped.
    repeat (6) @(negedge clk);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    push_byte(8'h5A);
    push_byte(8'h96);
    wait_start("midrst");
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", 64'(tx), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_frame("midrst_next_96", 8'h96);
    repeat (6) @(negedge clk);
    check("midrst_rd_pulses", 64'(rd_cnt - rd0), 64'd2);
    check("midrst_done_pulses", 64'(done_cnt - dn0), 64'd1);
    check("midrst_stray_frames", 64'(frames.size()), 64'd0);

    // Randomised bytes with random write spacing.
    rd0 = rd_cnt;
    dn0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      rand_q.push_back(rb);
      push_byte(rb);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      expect_frame($sformatf("rand_%0d", i), rand_q[i]);
    end
    repeat (6) @(negedge clk);
    check("rand_rd_pulses", 64'(rd_cnt - rd0), 64'd6);
    check("rand_done_pulses", 64'(done_cnt - dn0), 64'd6);
    check("rand_empty_after", 64'(fifo_empty), 64'd1);

    check("pop_while_empty", 64'(bad_pop), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO's read handshake (rd_en / empty / data_out) and serialises it on a UART line: 8N1, LSB first.
- Sits between the FIFO and the chip pin. It is the drain end of the buffer that upstream logic fills through wr_en / data_in.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit. Legal values are 2 and above. Counter width is clog2(CLKS_PER_BIT).
- DATA_W, 8, bits per frame. Must match the FIFO width. Only 8 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  permits fetching a new byte; sampled only in IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  8  FIFO data_out; valid the cycle after an accepted rd_en
- fifo_rd_en  out  1  one-cycle pop request to FIFO (registered)
- tx  out  1  serial line, idle high (registered)
- busy  out  1  high from REQ through end of STOP
- tx_done  out  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset values (applied asynchronously): state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, shift register=0, counters=0.
- IDLE:
  - tx=1, busy=0.
  - If enable=1 and fifo_empty=0: fifo_rd_en<=1 and move to REQ.
  - Otherwise stay in IDLE.
- REQ (1 cycle): fifo_rd_en is high this cycle, then fifo_rd_en<=0 and move to WAIT. The FIFO pops at the end of REQ.
- WAIT (1 cycle):
  - shift<=fifo_data, tx<=0, bit_cnt<=0, clk_cnt<=0.
  - Move to START.
- START: tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0] and move to DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At the end of each bit period: shift right, bit_cnt++, tx<=next bit.
  - After bit 7 completes: tx<=1 and move to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle.
  - Then move to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles of line time (start + 8 data + stop).
- Fetch gap: IDLE→REQ→WAIT adds 3 cycles of idle-high between back-to-back frames when the FIFO is non-empty.
- fifo_rd_en: exactly one pulse per transmitted byte. It is never asserted while fifo_empty=1 (checked in IDLE), and never asserted outside REQ.
- enable deasserted mid-frame: the current frame completes normally; no further fetch occurs until enable returns high in IDLE.
- fifo_empty rising during a frame: no effect on the current frame.
- Reset mid-frame: tx returns to 1 immediately and the byte in flight is dropped (it was already popped from the FIFO). No pulse is emitted on fifo_rd_en or tx_done.
- Simultaneous FIFO write while this block pops: handled by the FIFO. This block only observes fifo_empty in IDLE.

Test Plan (CLKS_PER_BIT=4, FIFO instance connected; write side driven by bench):
- Reset check: hold rst=1 for 2 cycles, then release with FIFO empty and enable=1. Required: tx=1, busy=0, fifo_rd_en=0 throughout 50 cycles.
- Single byte: write 0x05, enable=1.
  - Exactly one fifo_rd_en pulse.
  - tx bit sequence 0,1,0,1,0,0,0,0,0,1, each bit 4 cycles (40 cycles total).
  - tx_done pulses once.
  - FIFO empty=1 afterwards.
- Back-to-back: write 0x05 then 0x0A.
  - Two frames in order: second data bits 0,1,0,1,0,0,0,0.
  - Idle-high gap between frames of 3 cycles.
  - Two rd_en pulses and two tx_done pulses.
- Enable gating: write 0xFF with enable=0 for 30 cycles. Required: no rd_en, tx=1. Then raise enable: frame 0,1×8,1 sent.
- Mid-frame disable: write 0xA5, 0x3C. Drop enable during the first frame's DATA state. Required: frame 0xA5 completes; 0x3C stays in FIFO (empty=0); no second rd_en.
- Reset mid-frame: assert rst during bit 3 of 0x5A. Required: tx=1 within the same cycle (async); busy=0. After release with enable=1, the next FIFO byte is transmitted correctly.
